imm_decode_pipe: RTL and testbench
==================================

Name: imm_decode_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate generator.
- Decodes the immediate, format and legality of every RV32I base opcode.
- Sign-extends the immediate to XLEN (32 or 64).
- Carries a sideband tag (normally the PC) through an elastic valid/ready pipeline of STAGES registers, with flush. Sits between fetch and the register-read/execute stage.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64
STAGES, 1, number of register stages between input and output; legal range 1..4
TAG_W, 32, width of the sideband tag carried with each instruction

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous; invalidates all in-flight entries
in_valid  input  1  in_instr/in_tag are valid
in_ready  output  1  pipeline can accept this cycle
in_instr  input  32  raw instruction word
in_tag  input  TAG_W  sideband tag
out_valid  output  1  output entry valid
out_ready  input  1  consumer accepts output this cycle
out_imm  output  XLEN  sign- or zero-extended immediate
out_fmt  output  3  format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
out_illegal  output  1  unrecognised opcode, or instr[1:0] != 2'b11
out_tag  output  TAG_W  tag of the output entry

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all stage valid bits 0; out_valid 0, out_imm 0, out_fmt 0, out_illegal 0, out_tag 0. Reset mid-stream discards all entries with no output.
- Decode: combinational on in_instr and captured into stage 0. Later stages only copy data.
- Opcode to format and immediate (sign bit = instr[31], extended to XLEN):
  - 0000011, 0010011, 1100111, 0001111 -> I: instr[31:20].
  - 0100011 -> S: {instr[31:25], instr[11:7]}.
  - 1100011 -> B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111, 0010111 -> U: {instr[31:12], 12'b0}, sign-extended above bit 31. For XLEN=32 no extension bits exist.
  - 1101111 -> J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 0110011 (R) and 1110011 (SYSTEM) -> fmt 0, imm 0, legal.
  - Any other opcode -> fmt 0, imm 0, out_illegal 1.
- Handshake: an entry transfers when valid and ready are both high.
  - Stage i ready = ~valid[i] | ready[i+1]; ready[STAGES] = out_ready.
  - in_ready = ready[0], combinational from out_ready through the chain.
  - Output data is stable while out_valid=1 and out_ready=0.
  - Bubbles collapse: a stalled head does not block earlier empty stages from filling.
- Latency: STAGES cycles from the accept edge to out_valid with no stall. Throughput 1/cycle with out_ready held high.
- Full: all STAGES valid and out_ready=0 -> in_ready=0; in_valid is ignored.
- Empty: out_valid=0; out_imm/out_fmt/out_illegal/out_tag hold their last values and are don't-care.
- Flush: all valid bits clear on the next edge. Flush takes priority over a same-cycle input accept; that input is dropped. in_ready is unaffected by flush. An output handshake in the flush cycle still counts as delivered.

Optional Feature:
IMM_ZICSR_EN
- Defined: opcode 1110011 with funct3[2]=1 (csrrwi/csrrsi/csrrci) gives fmt 6, imm = zero-extended instr[19:15].
- Undefined: these instructions give fmt 0, imm 0, not illegal, like any other SYSTEM instruction.

Test Plan:
- STAGES=1, XLEN=32: 0xFFC12083 (lw x1,-4(x2)) -> out_imm 0xFFFFFFFC, fmt 1, out_valid exactly 1 cycle after accept. 0xFE112E23 (sw) -> 0xFFFFFFFC, fmt 2.
- 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt 3. 0x001000EF (jal x1,+2048) -> 0x00000800, fmt 5. 0x0000007F -> imm 0, out_illegal 1.
- 0x800000B7 (lui x1,0x80000): XLEN=32 -> 0x80000000; XLEN=64 -> 0xFFFFFFFF80000000; fmt 4 in both.
- STAGES=3, out_ready=0, push 4 back-to-back -> in_ready drops after the 3rd accept. Raise out_ready -> tags appear in order, one per cycle, none lost or duplicated.
- STAGES=2, two entries in flight, flush with in_valid=1 -> out_valid 0 next cycle, the flush-cycle input is dropped, and the next accepted entry emerges 2 cycles later.
- IMM_ZICSR_EN defined: 0x300FD073 (csrrwi x0,0x300,31) -> out_imm 0x1F, fmt 6. Undefined -> imm 0, fmt 0, out_illegal 0.

Source files
------------

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: RV32I immediate/format/legality decoder feeding an elastic valid/ready pipeline of STAGES registers.
// Optional macro IMM_ZICSR_EN decodes the CSR-immediate (zimm) forms as format 6.
module imm_decode_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  logic [31:0]      w_imm32;
  logic [2:0]       w_fmt;
  logic             w_illegal;
  logic [XLEN-1:0]  w_imm;
  logic [STAGES-1:0] w_rdy;
  logic [STAGES:0]  w_c_v;
  logic [STAGES:0]  w_c_ill;
  logic [XLEN-1:0]  w_c_imm [STAGES+1];
  logic [2:0]       w_c_fmt [STAGES+1];
  logic [TAG_W-1:0] w_c_tag [STAGES+1];
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_ill;
  logic [XLEN-1:0]  r_imm [STAGES];
  logic [2:0]       r_fmt [STAGES];
  logic [TAG_W-1:0] r_tag [STAGES];
  always_comb begin
    w_imm32   = '0;
    w_fmt     = 3'd0;
    w_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        w_fmt   = 3'd1;
      end
      7'b0100011: begin
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        w_fmt   = 3'd2;
      end
      7'b1100011: begin
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        w_fmt   = 3'd3;
      end
      7'b0110111, 7'b0010111: begin
        w_imm32 = {in_instr[31:12], 12'b0};
        w_fmt   = 3'd4;
      end
      7'b1101111: begin
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        w_fmt   = 3'd5;
      end
      7'b0110011: w_fmt = 3'd0;
      7'b1110011: begin
`ifdef IMM_ZICSR_EN
        w_imm32 = in_instr[14] ? {27'b0, in_instr[19:15]} : 32'b0;
        w_fmt   = in_instr[14] ? 3'd6 : 3'd0;
`else
        w_fmt   = 3'd0;
`endif
      end
      default: w_illegal = 1'b1;
    endcase
  end
  // Every 32-bit immediate already carries its sign in bit 31, so one extension covers all formats.
  assign w_imm = XLEN'($signed(w_imm32));
  // Stage s can take data whenever any stage from s to the head is empty, or the consumer drains the head.
  always_comb begin
    w_c_v   = {r_valid, in_valid};
    w_c_ill = {r_ill, w_illegal};
    w_c_imm[0] = w_imm;
    w_c_fmt[0] = w_fmt;
    w_c_tag[0] = in_tag;
    w_rdy = '0;
    for (int s = 0; s < STAGES; s++) begin
      w_c_imm[s+1] = r_imm[s];
      w_c_fmt[s+1] = r_fmt[s];
      w_c_tag[s+1] = r_tag[s];
      w_rdy[s]     = out_ready | ~&(r_valid | STAGES'((1 << s) - 1));
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_ill   <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_imm[s] <= '0;
        r_fmt[s] <= '0;
        r_tag[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= ~flush & (w_rdy[s] ? w_c_v[s] : r_valid[s]);
        if (w_rdy[s] && w_c_v[s]) begin
          r_imm[s] <= w_c_imm[s];
          r_fmt[s] <= w_c_fmt[s];
          r_ill[s] <= w_c_ill[s];
          r_tag[s] <= w_c_tag[s];
        end
      end
    end
  end
  assign in_ready    = w_rdy[0];
  assign out_valid   = r_valid[STAGES-1];
  assign out_imm     = r_imm[STAGES-1];
  assign out_fmt     = r_fmt[STAGES-1];
  assign out_illegal = r_ill[STAGES-1];
  assign out_tag     = r_tag[STAGES-1];
endmodule

// File: tb/tb_imm_decode_pipe.sv
// tb_imm_decode_pipe: scoreboard bench over three imm_decode_pipe configurations
// (STAGES=1/XLEN=32, STAGES=3/XLEN=64, STAGES=2/XLEN=32).
module tb_imm_decode_pipe;
  localparam int N = 3;
  typedef struct {
    int          inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  flush = '0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  out_ready = '0;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ill;
  logic [31:0]   in_instr [N];
  logic [31:0]   in_tag [N];
  logic [63:0]   out_imm [N];
  logic [2:0]    out_fmt [N];
  logic [31:0]   out_tag [N];
  exp_t          sbq[$];
  exp_t          m_e;
  int            n_cmp = 0;
  int            n_bad = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int ST = (k == 1) ? 3 : (k == 2) ? 2 : 1;
    localparam int XL = (k == 1) ? 64 : 32;
    logic [XL-1:0] w_imm;
    imm_decode_pipe #(.XLEN(XL), .STAGES(ST), .TAG_W(32)) u_dut (
      .clk(clk), .reset(rst), .flush(flush[k]),
      .in_valid(in_valid[k]), .in_ready(in_ready[k]),
      .in_instr(in_instr[k]), .in_tag(in_tag[k]),
      .out_valid(out_valid[k]), .out_ready(out_ready[k]),
      .out_imm(w_imm), .out_fmt(out_fmt[k]),
      .out_illegal(out_ill[k]), .out_tag(out_tag[k])
    );
    assign out_imm[k] = 64'(w_imm);
  end
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst && out_valid[k] && out_ready[k]) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out inst %0d: got tag=%h, required no output", k, out_tag[k]);
        end else begin
          m_e = sbq.pop_front();
          if (m_e.inst != k || out_imm[k] !== m_e.imm || out_fmt[k] !== m_e.fmt ||
              out_ill[k] !== m_e.ill || out_tag[k] !== m_e.tag) begin
            n_bad++;
            $display("FAIL out inst %0d: got imm=%h fmt=%0d ill=%0b tag=%h, required inst %0d imm=%h fmt=%0d ill=%0b tag=%h",
                     k, out_imm[k], out_fmt[k], out_ill[k], out_tag[k],
                     m_e.inst, m_e.imm, m_e.fmt, m_e.ill, m_e.tag);
          end
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask
  task automatic send(input int k, input logic [31:0] ins, input logic [31:0] tg,
                      input logic [63:0] imm, input logic [2:0] fmt, input logic ill, input bit exp_out);
    bit ok = 1'b0;
    in_instr[k] = ins;
    in_tag[k]   = tg;
    in_valid[k] = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready[k];
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout inst %0d tag %h: got in_ready=0, required 1 within 100 cycles", k, tg);
    end else if (exp_out) begin
      sbq.push_back('{k, imm, fmt, ill, tg});
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000 time units");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < N; k++) begin
      in_instr[k] = '0;
      in_tag[k]   = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset_ctl%0d", k), {27'b0, out_valid[k], out_fmt[k], out_ill[k], out_tag[k]}, 64'd0);
      chk($sformatf("reset_imm%0d", k), out_imm[k], 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = '1;
    // STAGES=1, XLEN=32: decode table and one-cycle latency
    chk("a_empty", out_valid[0], 1'b0);
    send(0, 32'hFFC12083, 32'h1, 64'hFFFFFFFC, 3'd1, 1'b0, 1'b1);
    chk("a_latency", out_valid[0], 1'b1);
    send(0, 32'hFE112E23, 32'h2, 64'hFFFFFFFC, 3'd2, 1'b0, 1'b1);
    send(0, 32'hFE000CE3, 32'h3, 64'hFFFFFFF8, 3'd3, 1'b0, 1'b1);
    send(0, 32'h001000EF, 32'h4, 64'h00000800, 3'd5, 1'b0, 1'b1);
    send(0, 32'h0000007F, 32'h5, 64'h0,        3'd0, 1'b1, 1'b1);
    send(0, 32'h800000B7, 32'h6, 64'h80000000, 3'd4, 1'b0, 1'b1);
    send(0, 32'h002081B3, 32'h7, 64'h0,        3'd0, 1'b0, 1'b1);
    send(0, 32'h00001097, 32'h8, 64'h00001000, 3'd4, 1'b0, 1'b1);
    send(0, 32'h7FF00093, 32'h9, 64'h000007FF, 3'd1, 1'b0, 1'b1);
    send(0, 32'h0FF0000F, 32'hA, 64'h000000FF, 3'd1, 1'b0, 1'b1);
    send(0, 32'h000080E7, 32'hB, 64'h0,        3'd1, 1'b0, 1'b1);
    send(0, 32'h00000073, 32'hC, 64'h0,        3'd0, 1'b0, 1'b1);
`ifdef IMM_ZICSR_EN
    send(0, 32'h300FD073, 32'hD, 64'h1F,       3'd6, 1'b0, 1'b1);
`else
    send(0, 32'h300FD073, 32'hD, 64'h0,        3'd0, 1'b0, 1'b1);
`endif
    send(0, 32'h00000001, 32'hE, 64'h0,        3'd0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    // STAGES=3, XLEN=64: fill while stalled, then drain in order
    out_ready[1] = 1'b0;
    send(1, 32'h800000B7, 32'h100, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b1);
    send(1, 32'hFFC12083, 32'h101, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0, 1'b1);
    send(1, 32'h001000EF, 32'h102, 64'h0000000000000800, 3'd5, 1'b0, 1'b1);
    in_instr[1] = 32'h0000007F;
    in_tag[1]   = 32'h103;
    in_valid[1] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("b_full_in_ready", in_ready[1], 1'b0);
      chk("b_stall_tag", out_tag[1], 64'h100);
    end
    chk("b_stall_valid", out_valid[1], 1'b1);
    @(posedge clk);
    #1;
    out_ready[1] = 1'b1;
    fork
      send(1, 32'h0000007F, 32'h103, 64'h0, 3'd0, 1'b1, 1'b1);
      repeat (4) begin
        @(negedge clk);
        chk("b_stream_valid", out_valid[1], 1'b1);
      end
    join
    @(posedge clk);
    #1;
    chk("b_drained", out_valid[1], 1'b0);
    // STAGES=2: flush with two in flight and a same-cycle input
    send(2, 32'hFE000CE3, 32'h200, 64'hFFFFFFF8, 3'd3, 1'b0, 1'b1);
    send(2, 32'hFFC12083, 32'h201, 64'hFFFFFFFC, 3'd1, 1'b0, 1'b0);
    flush[2]    = 1'b1;
    in_instr[2] = 32'h001000EF;
    in_tag[2]   = 32'h202;
    in_valid[2] = 1'b1;
    @(negedge clk);
    chk("c_flush_in_ready", in_ready[2], 1'b1);
    @(posedge clk);
    #1;
    flush[2]    = 1'b0;
    in_valid[2] = 1'b0;
    chk("c_flush_clear", out_valid[2], 1'b0);
    send(2, 32'hFE112E23, 32'h203, 64'hFFFFFFFC, 3'd2, 1'b0, 1'b1);
    chk("c_lat1", out_valid[2], 1'b0);
    @(posedge clk);
    #1;
    chk("c_lat2", out_valid[2], 1'b1);
    repeat (3) @(posedge clk);
    #1;
    // Reset mid-stream discards the held entry
    out_ready[0] = 1'b0;
    send(0, 32'hFFC12083, 32'h300, 64'hFFFFFFFC, 3'd1, 1'b0, 1'b0);
    chk("d_held", out_tag[0], 64'h300);
    rst = 1'b1;
    #1;
    chk("d_reset_valid", out_valid[0], 1'b0);
    chk("d_reset_tag", out_tag[0], 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
